reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter: CNT_W, 2, width of per-register in-flight write counter; per-register maximum MAXC = 2^CNT_W-1.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: issue_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have port: issue_rs1, issue_rs2  input  5 each  source register numbers.
REQ-006 SHALL have port: use_rs1, use_rs2  input  1 each  source operand actually read.
REQ-007 SHALL have port: issue_wr  input  1  instruction writes issue_rd.
REQ-008 SHALL have port: issue_rd  input  5  destination register number.
REQ-009 SHALL have port: wb_valid  input  1  writeback stage retires a RegWrite to wb_rd this cycle.
REQ-010 SHALL have port: wb_rd  input  5  writeback destination register.
REQ-011 SHALL have port: flush  input  1  pipeline squash; discards all in-flight tracking.
REQ-012 SHALL have port: stall  output  1  combinational; decode must hold the instruction.
REQ-013 SHALL have port: issue_accept  output  1  combinational; issue_valid & ~stall & ~flush.
REQ-014 SHALL have port: busy  output  32  bit r = 1 when count[r] != 0; bit 31 always 0.
REQ-015 SHALL have port: total_pending  output  7  sum of all per-register counts.
REQ-016 SHALL have port: err  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL hold one CNT_W-bit counter count[r] for r = 0..30; register 31 (zero register) SHALL have no state and SHALL never be busy, stall or count.
REQ-018 SHALL assert stall when issue_valid and any of: use_rs1 & busy[issue_rs1]; use_rs2 & busy[issue_rs2]; issue_wr & issue_rd != 31 & count[issue_rd] == MAXC.
REQ-019 SHALL compute stall from registered counts only; a same-cycle wb_valid to a source register SHALL NOT remove the stall (released the following cycle).
REQ-020 SHALL deassert stall whenever issue_valid = 0.
REQ-021 On issue_accept & issue_wr & issue_rd != 31, count[issue_rd] SHALL increment by 1 at the next edge.
REQ-022 On wb_valid & wb_rd != 31 & count[wb_rd] != 0, count[wb_rd] SHALL decrement by 1 at the next edge.
REQ-023 Accepted issue and writeback to the same register in the same cycle SHALL leave that count unchanged.
REQ-024 wb_valid with wb_rd == 31 SHALL be ignored without error.
REQ-025 wb_valid to a register whose count is 0 SHALL leave the count at 0 (no wrap) and set err at the next edge.
REQ-026 A counter SHALL never wrap above MAXC; REQ-018 guarantees no increment at MAXC.
REQ-027 flush SHALL clear every count to 0 at the next edge, with priority over same-cycle issue and writeback; issue_accept SHALL be 0 while flush = 1.
REQ-028 err SHALL remain set until reset; flush SHALL NOT clear err.
REQ-029 total_pending SHALL be a registered value equal to the sum of count[0..30] after each edge (maximum 93 for CNT_W = 2).
REQ-030 busy SHALL be derived from registered counts, updating one cycle after the causing issue or writeback.

Reset
REQ-031 reset_n low SHALL immediately and asynchronously clear all counts, total_pending and err to 0; busy SHALL read 0.
REQ-032 While reset_n is low, stall SHALL follow REQ-018 on zero counts (i.e. 0); accepted issues SHALL NOT be recorded until reset_n is high at an edge.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight state identically to power-up.

Verification
REQ-034 Issue rd=5 (issue_wr=1), next cycle issue rs1=5 use_rs1=1 -> busy[5]=1, stall=1 until the cycle after wb_valid wb_rd=5, then stall=0.
REQ-035 Three accepted writes to rd=7 without writeback, fourth issue to rd=7 -> count[7]=3, total_pending=3, fourth stalled; one wb to 7 -> fourth accepted next cycle.
REQ-036 Same-cycle accepted issue rd=9 and wb wb_rd=9 with count[9]=1 -> count[9] stays 1, busy[9]=1.
REQ-037 Issue rd=31 and wb wb_rd=31 -> busy=0, total_pending=0, err=0, no stall on rs1=31.
REQ-038 wb_valid wb_rd=3 with count[3]=0 -> err=1, count[3]=0; subsequent flush -> err still 1.
REQ-039 Pending writes to rd=1,2,4, then flush with simultaneous issue rd=6 -> all counts 0, issue_accept=0; reset_n pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register in-flight write counters; generates decode stall.
// Revision : 1.0
// ============================================================================
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic        issue_accept,
  output logic [31:0] busy,
  output logic [6:0]  total_pending,
  output logic        err
);

  localparam int c_NREG = 31;

  logic [31:0]               w_busy;
  logic [31:0]               w_full;
  logic [c_NREG*CNT_W-1:0]   w_nxt_flat;
  logic                      w_wr_track;
  logic                      w_wb_track;
  logic                      w_err_set;
  logic [6:0]                w_sum;
  logic [6:0]                r_total;
  logic                      r_err;

  // Register 31 is the zero register: never tracked, never busy.
  assign w_wr_track = issue_wr & (issue_rd != 5'd31);
  assign w_wb_track = wb_valid & (wb_rd != 5'd31);

  assign stall = issue_valid &
                 ((use_rs1 & w_busy[issue_rs1]) |
                  (use_rs2 & w_busy[issue_rs2]) |
                  (w_wr_track & w_full[issue_rd]));

  assign issue_accept = issue_valid & ~stall & ~flush;
  assign w_err_set    = w_wb_track & ~w_busy[wb_rd];

  generate
    for (genvar gi = 0; gi < c_NREG; gi++) begin : g_reg
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_nxt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = issue_accept & w_wr_track & (issue_rd == 5'(gi));
      assign w_dec = w_wb_track & (wb_rd == 5'(gi)) & (r_cnt != '0);

      always_comb begin
        w_nxt = r_cnt;
        if (flush)
          w_nxt = '0;
        else if (w_inc && !w_dec)
          w_nxt = r_cnt + CNT_W'(1);
        else if (w_dec && !w_inc)
          w_nxt = r_cnt - CNT_W'(1);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          r_cnt <= '0;
        else
          r_cnt <= w_nxt;
      end

      assign w_busy[gi] = |r_cnt;
      assign w_full[gi] = &r_cnt;
      assign w_nxt_flat[gi*CNT_W +: CNT_W] = w_nxt;
    end
  endgenerate

  assign w_busy[31] = 1'b0;
  assign w_full[31] = 1'b0;

  // Total is registered from the next-state counts so it tracks them exactly.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < c_NREG; i++)
      w_sum = w_sum + 7'(w_nxt_flat[i*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total <= '0;
      r_err   <= 1'b0;
    end else begin
      r_total <= w_sum;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  assign busy          = w_busy;
  assign total_pending = r_total;
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Table vectors, corner sequences and random model check.
// Revision : 1.0
// ============================================================================
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid, use_rs1, use_rs2, issue_wr, wb_valid, flush;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        stall, issue_accept, err;
  logic [31:0] busy;
  logic [6:0]  total_pending;

  int n_vec = 0;
  int n_err = 0;
  int mcnt[32];
  bit merr;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .use_rs1(use_rs1),
    .use_rs2(use_rs2), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
    .issue_accept(issue_accept), .busy(busy), .total_pending(total_pending),
    .err(err)
  );

  typedef struct {
    logic iv; logic [4:0] rs1; logic u1; logic wr; logic [4:0] rd;
    logic wb; logic [4:0] wbrd; logic fl;
    logic e_stall; logic e_acc; logic [31:0] e_busy; logic [6:0] e_tot; logic e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic iv, logic [4:0] rs1, logic u1, logic wr,
                              logic [4:0] rd, logic wb, logic [4:0] wbrd, logic fl,
                              logic es, logic ea, logic [31:0] eb, logic [6:0] et,
                              logic ee);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.wr = wr; v.rd = rd; v.wb = wb;
    v.wbrd = wbrd; v.fl = fl; v.e_stall = es; v.e_acc = ea; v.e_busy = eb;
    v.e_tot = et; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid = 0; use_rs1 = 0; use_rs2 = 0; issue_wr = 0; wb_valid = 0; flush = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    #2 reset_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_total", 32'(total_pending), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 0;
  endtask

  // Reference model: one cycle of scoreboard rules applied to integer counts.
  task automatic model_cycle();
    bit es, ea;
    int nc[32];
    int tot;
    logic [31:0] eb;
    es = issue_valid && ((use_rs1 && mcnt[issue_rs1] > 0) ||
                         (use_rs2 && mcnt[issue_rs2] > 0) ||
                         (issue_wr && issue_rd != 31 && mcnt[issue_rd] == MAXC));
    ea = issue_valid && !es && !flush;
    #1;
    chk("m_stall", 32'(stall), 32'(es));
    chk("m_accept", 32'(issue_accept), 32'(ea));
    nc = mcnt;
    if (wb_valid && wb_rd != 31) begin
      if (mcnt[wb_rd] == 0) merr = 1;
      else nc[wb_rd] = nc[wb_rd] - 1;
    end
    if (ea && issue_wr && issue_rd != 31) nc[issue_rd] = nc[issue_rd] + 1;
    if (flush) for (int i = 0; i < 32; i++) nc[i] = 0;
    mcnt = nc;
    @(posedge clk);
    #1;
    tot = 0; eb = 0;
    for (int i = 0; i < 31; i++) begin
      tot += mcnt[i];
      eb[i] = (mcnt[i] != 0);
    end
    chk("m_busy", busy, eb);
    chk("m_total", 32'(total_pending), 32'(tot));
    chk("m_err", 32'(err), 32'(merr));
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 9);
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset_n = 0;
    idle();
    // iv rs1 u1 wr rd  wb wbrd fl | stall acc busy total err
    tbl[0]  = mk(1, 0, 0, 1,  5, 0,  0, 0, 0, 1, 32'h20, 1, 0);
    tbl[1]  = mk(1, 5, 1, 0,  0, 0,  0, 0, 1, 0, 32'h20, 1, 0);
    tbl[2]  = mk(1, 5, 1, 0,  0, 1,  5, 0, 1, 0, 32'h0,  0, 0);
    tbl[3]  = mk(1, 5, 1, 0,  0, 0,  0, 0, 0, 1, 32'h0,  0, 0);
    tbl[4]  = mk(1, 0, 0, 1,  7, 0,  0, 0, 0, 1, 32'h80, 1, 0);
    tbl[5]  = mk(1, 0, 0, 1,  7, 0,  0, 0, 0, 1, 32'h80, 2, 0);
    tbl[6]  = mk(1, 0, 0, 1,  7, 0,  0, 0, 0, 1, 32'h80, 3, 0);
    tbl[7]  = mk(1, 0, 0, 1,  7, 0,  0, 0, 1, 0, 32'h80, 3, 0);
    tbl[8]  = mk(1, 0, 0, 1,  7, 1,  7, 0, 1, 0, 32'h80, 2, 0);
    tbl[9]  = mk(1, 0, 0, 1,  7, 0,  0, 0, 0, 1, 32'h80, 3, 0);
    tbl[10] = mk(1, 0, 0, 1,  9, 0,  0, 0, 0, 1, 32'h280, 4, 0);
    tbl[11] = mk(1, 0, 0, 1,  9, 1,  9, 0, 0, 1, 32'h280, 4, 0);
    tbl[12] = mk(1, 31, 1, 1, 31, 1, 31, 0, 0, 1, 32'h280, 4, 0);
    tbl[13] = mk(1, 0, 0, 1,  6, 1,  7, 1, 0, 0, 32'h0,  0, 0);
    tbl[14] = mk(0, 0, 0, 0,  0, 1,  3, 0, 0, 0, 32'h0,  0, 1);
    tbl[15] = mk(0, 0, 0, 0,  0, 0,  0, 1, 0, 0, 32'h0,  0, 1);

    repeat (2) @(negedge clk);
    chk("por_busy", busy, 0);
    chk("por_total", 32'(total_pending), 0);
    reset_n = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      issue_valid = tbl[i].iv; issue_rs1 = tbl[i].rs1; use_rs1 = tbl[i].u1;
      issue_wr = tbl[i].wr; issue_rd = tbl[i].rd; wb_valid = tbl[i].wb;
      wb_rd = tbl[i].wbrd; flush = tbl[i].fl; use_rs2 = 0; issue_rs2 = 0;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_accept", i), 32'(issue_accept), 32'(tbl[i].e_acc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_total", i), 32'(total_pending), 32'(tbl[i].e_tot));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e_err));
    end

    // Pending writes to 1,2,4, then flush with a simultaneous issue to 6.
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      if (r == 3) continue;
      @(negedge clk);
      idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5'(r);
    end
    @(negedge clk);
    idle();
    chk("seq_busy", busy, 32'h16);
    chk("seq_total", 32'(total_pending), 3);
    issue_valid = 1; issue_wr = 1; issue_rd = 6; flush = 1;
    #1 chk("seq_flush_acc", 32'(issue_accept), 0);
    @(negedge clk);
    idle();
    chk("seq_flush_busy", busy, 0);
    chk("seq_flush_total", 32'(total_pending), 0);

    // Build state and err, then reset asynchronously mid-cycle while issuing.
    issue_valid = 1; issue_wr = 1; issue_rd = 2; wb_valid = 1; wb_rd = 3;
    @(negedge clk);
    chk("seq_err", 32'(err), 1);
    chk("seq_pre_busy", busy, 32'h4);
    issue_rd = 2; use_rs1 = 1; issue_rs1 = 8; wb_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_total", 32'(total_pending), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_stall", 32'(stall), 0);
    @(negedge clk);
    chk("arst_hold_total", 32'(total_pending), 0);
    chk("arst_hold_busy", busy, 0);
    idle();
    reset_n = 1;
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 0;

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) do_reset();
      @(negedge clk);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rs1 = pick(); issue_rs2 = pick(); issue_rd = pick();
      use_rs1 = $urandom_range(0, 1) != 0;
      use_rs2 = $urandom_range(0, 2) == 0;
      issue_wr = $urandom_range(0, 3) != 0;
      wb_valid = $urandom_range(0, 1) != 0;
      wb_rd = pick();
      if ($urandom_range(0, 19) != 0) begin
        int s;
        s = $urandom_range(0, 30);
        for (int k = 0; k < 31; k++)
          if (mcnt[(s + k) % 31] > 0) begin
            wb_rd = 5'((s + k) % 31);
            break;
          end
      end
      flush = ($urandom_range(0, 49) == 0);
      model_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
